// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: start/stop/pause sequencer around a 26-bit up-counter with threshold compare.
// Latency: cnt/out/done/wrap_cnt are registered and reflect a sampled control input one cycle later.
// Backpressure: cfg_ready is high only in IDLE/DONE; offers made in RUN/HOLD are dropped, not queued.
// Ports:
//   sys_clk, sys_rst_n              clock, async active-low reset
//   cfg_valid/cfg_ready             config handshake; cfg_period, cfg_compare, cfg_oneshot payload
//   start, stop, pause              control (priority stop > start > pause)
//   cnt, out, busy, done, wrap_cnt  count, threshold, RUN/HOLD flag, end-of-period pulse, period tally
module timer_seq_ctrl #(
  parameter logic [25:0] DEF_PERIOD  = 26'd49_999_999,
  parameter logic [25:0] DEF_CMP     = 26'd25_000_000,
  parameter logic        DEF_ONESHOT = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [25:0] cfg_period,
  input  logic [25:0] cfg_compare,
  input  logic        cfg_oneshot,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  output logic [25:0] cnt,
  output logic        out,
  output logic        busy,
  output logic        done,
  output logic [7:0]  wrap_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t      state, state_nxt;
  logic [25:0] period_q, cmp_q;
  logic        oneshot_q;
  logic [25:0] cnt_nxt;
  logic [7:0]  wrap_nxt;
  logic        done_nxt;
  logic        out_nxt;
  logic        cfg_acc;
  logic [25:0] cmp_eff;

  assign cfg_ready = (state == IDLE) || (state == DONE);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign busy      = (state == RUN) || (state == HOLD);

  // A start issued alongside a config accept must compare against the new
  // threshold on its very first RUN cycle, so look through the register.
  assign cmp_eff = cfg_acc ? cfg_compare : cmp_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wrap_nxt  = wrap_cnt;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      cnt_nxt   = 26'd0;
    end else if (start) begin
      state_nxt = RUN;
      cnt_nxt   = 26'd0;
      wrap_nxt  = 8'd0;
    end else begin
      case (state)
        RUN: begin
          // Terminal count wins over pause so a period is never stretched.
          if (cnt == period_q) begin
            done_nxt = 1'b1;
            cnt_nxt  = 26'd0;
            if (wrap_cnt != 8'd255) wrap_nxt = wrap_cnt + 8'd1;
            if (oneshot_q) state_nxt = DONE;
          end else if (pause) begin
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt + 26'd1;
          end
        end
        HOLD: begin
          // Leave HOLD with the frozen value; counting picks up next cycle.
          if (!pause) state_nxt = RUN;
        end
        default: ;
      endcase
    end
    // Registered out is computed from next-state values so it tracks cnt with no lag.
    out_nxt = ((state_nxt == RUN) || (state_nxt == HOLD)) && (cnt_nxt >= cmp_eff);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cnt       <= 26'd0;
      out       <= 1'b0;
      done      <= 1'b0;
      wrap_cnt  <= 8'd0;
      period_q  <= DEF_PERIOD;
      cmp_q     <= DEF_CMP;
      oneshot_q <= DEF_ONESHOT;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      out      <= out_nxt;
      done     <= done_nxt;
      wrap_cnt <= wrap_nxt;
      if (cfg_acc) begin
        period_q  <= cfg_period;
        cmp_q     <= cfg_compare;
        oneshot_q <= cfg_oneshot;
      end
    end
  end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// tb_timer_seq_ctrl: randomized and directed stimulus against a cycle-level behavioural model.
// Latency: model is advanced once per clock and compared 1 time unit after each rising edge.
// Backpressure: config offers are driven freely; the model drops them while the timer is active.
module tb_timer_seq_ctrl;

  localparam logic [25:0] TB_DEF_PERIOD  = 26'd12;
  localparam logic [25:0] TB_DEF_CMP     = 26'd4;
  localparam logic        TB_DEF_ONESHOT = 1'b0;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [25:0] cfg_period;
  logic [25:0] cfg_compare;
  logic        cfg_oneshot;
  logic        start, stop, pause;
  logic [25:0] cnt;
  logic        out, busy, done;
  logic [7:0]  wrap_cnt;

  int errors = 0;
  int checks = 0;

  // Model: "active" covers RUN and HOLD; IDLE and DONE look identical from outside.
  logic        m_active, m_held, m_done, m_out, m_one;
  logic [25:0] m_cnt, m_per, m_cmp;
  logic [7:0]  m_wrap;

  logic [37:0] dut_vec;
  assign dut_vec = {cnt, out, busy, done, wrap_cnt, cfg_ready};

  timer_seq_ctrl #(
    .DEF_PERIOD (TB_DEF_PERIOD),
    .DEF_CMP    (TB_DEF_CMP),
    .DEF_ONESHOT(TB_DEF_ONESHOT)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_compare(cfg_compare),
    .cfg_oneshot(cfg_oneshot),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .cnt        (cnt),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .wrap_cnt   (wrap_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [37:0] exp_vec();
    return {m_cnt, m_out, m_active, m_done, m_wrap, ~m_active};
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_held = 1'b0; m_done = 1'b0; m_out = 1'b0;
    m_cnt = 26'd0; m_wrap = 8'd0;
    m_per = TB_DEF_PERIOD; m_cmp = TB_DEF_CMP; m_one = TB_DEF_ONESHOT;
  endtask

  // One clock of the timer, from the rules: stop beats start beats pause,
  // end of period beats pause, config only lands while inactive.
  task automatic model_step();
    logic acc;
    acc = cfg_valid && !m_active;
    if (stop) begin
      m_active = 1'b0; m_held = 1'b0; m_cnt = 26'd0; m_done = 1'b0;
    end else if (start) begin
      m_active = 1'b1; m_held = 1'b0; m_cnt = 26'd0; m_wrap = 8'd0; m_done = 1'b0;
    end else if (m_active && !m_held && m_cnt == m_per) begin
      m_done = 1'b1;
      if (m_wrap != 8'd255) m_wrap = m_wrap + 8'd1;
      m_cnt = 26'd0;
      if (m_one) m_active = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active && !m_held) begin
        if (pause) m_held = 1'b1;
        else m_cnt = m_cnt + 26'd1;
      end else if (m_active && m_held && !pause) begin
        m_held = 1'b0;
      end
    end
    if (acc) begin
      m_per = cfg_period; m_cmp = cfg_compare; m_one = cfg_oneshot;
    end
    m_out = m_active && (m_cnt >= m_cmp);
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; cfg_period = 26'd0; cfg_compare = 26'd0; cfg_oneshot = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic offer_cfg(input logic [25:0] p, input logic [25:0] c, input logic o);
    cfg_valid = 1'b1; cfg_period = p; cfg_compare = c; cfg_oneshot = o;
  endtask

  task automatic test_reset();
    idle_inputs();
    sys_rst_n = 1'b0;
    model_reset();
    #3;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec, exp_vec());
    end
    checks++;
    @(posedge sys_clk); @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL default_cfg cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_autoreload();
    stop = 1'b1; tick(); stop = 1'b0;
    offer_cfg(26'd9, 26'd5, 1'b0); tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL autoreload cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_oneshot();
    stop = 1'b1; tick(); stop = 1'b0;
    offer_cfg(26'd3, 26'd2, 1'b1); tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL oneshot cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_pause();
    bit hit;
    hit = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    offer_cfg(26'd9, 26'd2, 1'b0); tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_active && !m_held && m_cnt == 26'd4) hit = 1'b1;
      else tick();
    end
    if (!hit) begin
      errors++; $display("FAIL pause_reach_cnt4 got=%0d exp=4", cnt);
    end
    checks++;
    pause = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL pause_hold cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
    end
    pause = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL pause_resume cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_stop_priority();
    bit hit;
    hit = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    offer_cfg(26'd9, 26'd5, 1'b0); tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_cnt == 26'd7) hit = 1'b1;
      else tick();
    end
    if (!hit) begin
      errors++; $display("FAIL stop_reach_cnt7 got=%0d exp=7", cnt);
    end
    checks++;
    stop = 1'b1; start = 1'b1; pause = 1'b1;
    tick();
    idle_inputs();
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL stop_priority got=%h exp=%h", dut_vec, exp_vec());
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL stop_idle cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_cfg_blocked();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    offer_cfg(26'd2, 26'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL cfg_blocked cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL cfg_unchanged cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
    end
    stop = 1'b1; tick(); stop = 1'b0;
    offer_cfg(26'd2, 26'd1, 1'b0); start = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL cfg_with_start cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_boundaries();
    stop = 1'b1; tick(); stop = 1'b0;
    offer_cfg(26'd0, 26'd0, 1'b0); start = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 262; i++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL period0 cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
    end
    stop = 1'b1; tick(); stop = 1'b0;
    offer_cfg(26'd5, 26'd9, 1'b0); start = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 15; i++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL cmp_gt_period cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      stop        = ($urandom_range(99) < 3);
      start       = ($urandom_range(99) < 5);
      pause       = ($urandom_range(99) < 20);
      cfg_valid   = ($urandom_range(99) < 20);
      cfg_period  = 26'($urandom_range(12));
      cfg_compare = 26'($urandom_range(14));
      cfg_oneshot = 1'($urandom_range(1));
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    bit hit;
    logic [37:0] zero_vec;
    hit = 1'b0;
    zero_vec = {26'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
    stop = 1'b1; tick(); stop = 1'b0;
    offer_cfg(26'd9, 26'd5, 1'b0); tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_cnt == 26'd6) hit = 1'b1;
      else tick();
    end
    if (!hit) begin
      errors++; $display("FAIL areset_reach_cnt6 got=%0d exp=6", cnt);
    end
    checks++;
    #2;
    sys_rst_n = 1'b0;
    #1;
    if (dut_vec !== zero_vec) begin
      errors++; $display("FAIL areset_immediate got=%h exp=%h", dut_vec, zero_vec);
    end
    checks++;
    model_reset();
    @(posedge sys_clk); #1;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL areset_held got=%h exp=%h", dut_vec, exp_vec());
    end
    checks++;
    sys_rst_n = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL areset_defaults cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_autoreload();
    test_oneshot();
    test_pause();
    test_stop_priority();
    test_cfg_blocked();
    test_boundaries();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
